// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcode/funct encodings and the default datapath width.
// Small helper functions classify opcodes so the decode stage reads as intent, not bit patterns.
package mips_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic op_is_cond_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ);
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic op_imm_zext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/id_regfile.sv
// Register file, NREG x XLEN, r0 reads zero; two combinational read ports with write-through.
// Asynchronous active-low clear of every entry.
module id_regfile #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we_i,
  input  logic [$clog2(NREG)-1:0] wa_i,
  input  logic [XLEN-1:0]         wd_i,
  input  logic [$clog2(NREG)-1:0] ra_a_i,
  output logic [XLEN-1:0]         rd_a_o,
  input  logic [$clog2(NREG)-1:0] ra_b_i,
  output logic [XLEN-1:0]         rd_b_o
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] mem_q [NREG];
  logic            wr_ok;

  assign wr_ok = we_i && (wa_i != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  // Same-cycle write is visible to the reader, so WB->ID needs no extra bypass.
  always_comb begin
    rd_a_o = mem_q[ra_a_i];
    rd_b_o = mem_q[ra_b_i];
    if (ra_a_i == AW'(0))                rd_a_o = '0;
    else if (wr_ok && ra_a_i == wa_i)    rd_a_o = wd_i;
    if (ra_b_i == AW'(0))                rd_b_o = '0;
    else if (wr_ok && ra_b_i == wa_i)    rd_b_o = wd_i;
  end

endmodule

// File: rtl/id_stage_hz.sv
// MIPS decode stage: regfile, MEM bypass, load-use/branch hazard stall, early redirect,
// and the ID/EX register with valid/ready handshake plus a saturating stall counter.
module id_stage_hz
  import mips_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [31:0]             in_instr,
  input  logic                    ex_ready,
  input  logic                    flush,
  input  logic                    ex_wr_en,
  input  logic [$clog2(NREG)-1:0] ex_wr_addr,
  input  logic                    ex_is_load,
  input  logic                    mem_wr_en,
  input  logic [$clog2(NREG)-1:0] mem_wr_addr,
  input  logic [XLEN-1:0]         mem_data,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    out_valid,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_rs_data,
  output logic [XLEN-1:0]         out_rt_data,
  output logic [XLEN-1:0]         out_imm,
  output logic [31:0]             out_instr,
  output logic                    out_fwd_rs,
  output logic                    out_fwd_rt,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic [CNT_W-1:0]        stall_cnt
);

  localparam int AW = $clog2(NREG);

  // Instruction fields
  logic [5:0]      opcode, funct;
  logic [4:0]      rs_f, rt_f;
  logic [AW-1:0]   rs_a, rt_a;
  logic [15:0]     imm16;

  assign opcode = in_instr[31:26];
  assign rs_f   = in_instr[25:21];
  assign rt_f   = in_instr[20:16];
  assign funct  = in_instr[5:0];
  assign imm16  = in_instr[15:0];
  assign rs_a   = rs_f[AW-1:0];
  assign rt_a   = rt_f[AW-1:0];

  logic is_r, is_jr, is_jump, is_cbr, early_use;
  logic uses_rs, uses_rt;

  assign is_r      = (opcode == OP_RTYPE);
  assign is_jr     = is_r && (funct == FN_JR);
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_cbr    = op_is_cond_branch(opcode);
  assign early_use = is_cbr || is_jr;
  assign uses_rs   = !(is_jump || opcode == OP_LUI);
  assign uses_rt   = is_r || opcode == OP_BEQ || opcode == OP_BNE || op_is_store(opcode);

  // Register file and operand bypass
  logic [XLEN-1:0] rf_rs, rf_rt, rs_val, rt_val;

  id_regfile #(.XLEN(XLEN), .NREG(NREG)) u_rf (
    .clk    (clk),
    .reset  (reset),
    .we_i   (wb_en),
    .wa_i   (wb_addr),
    .wd_i   (wb_data),
    .ra_a_i (rs_a),
    .rd_a_o (rf_rs),
    .ra_b_i (rt_a),
    .rd_b_o (rf_rt)
  );

  always_comb begin
    rs_val = rf_rs;
    rt_val = rf_rt;
    if (rs_a == '0)                                rs_val = '0;
    else if (mem_wr_en && mem_wr_addr == rs_a)     rs_val = mem_data;
    if (rt_a == '0)                                rt_val = '0;
    else if (mem_wr_en && mem_wr_addr == rt_a)     rt_val = mem_data;
  end

  // EX-stage dependency: loads and early-resolved consumers must wait, the rest forward in EX.
  logic ex_hit_rs, ex_hit_rt, hazard, fwd_rs, fwd_rt;

  assign ex_hit_rs = in_valid && uses_rs && (rs_a != '0) && ex_wr_en && (ex_wr_addr == rs_a);
  assign ex_hit_rt = in_valid && uses_rt && (rt_a != '0) && ex_wr_en && (ex_wr_addr == rt_a);
  assign hazard    = (ex_hit_rs || ex_hit_rt) && (ex_is_load || early_use);
  assign fwd_rs    = ex_hit_rs && !hazard;
  assign fwd_rt    = ex_hit_rt && !hazard;

  logic valid_q, valid_d;

  assign in_ready = !hazard && (ex_ready || !valid_q);

  // Immediate and redirect targets
  logic [XLEN-1:0] imm_s, imm_ext, pc4, br_tgt, j_tgt;
  logic            taken, fire;

  assign imm_s   = {{(XLEN-16){imm16[15]}}, imm16};
  assign imm_ext = op_imm_zext(opcode) ? {{(XLEN-16){1'b0}}, imm16} : imm_s;
  assign pc4     = in_pc + XLEN'(4);
  assign br_tgt  = pc4 + (imm_s << 2);
  assign j_tgt   = {pc4[XLEN-1:28], in_instr[25:0], 2'b00};

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BEQ:  taken = (rs_val == rt_val);
      OP_BNE:  taken = (rs_val != rt_val);
      OP_BLEZ: taken = ($signed(rs_val) <= 0);
      OP_BGTZ: taken = ($signed(rs_val) > 0);
      default: taken = 1'b0;
    endcase
  end

  assign fire           = in_valid && in_ready && !flush;
  assign redirect_valid = fire && (taken || is_jump || is_jr);

  always_comb begin
    redirect_pc = br_tgt;
    if (is_jr)        redirect_pc = rs_val;
    else if (is_jump) redirect_pc = j_tgt;
  end

  // ID/EX register
  logic [XLEN-1:0]  pc_q, pc_d, rs_q, rs_d, rt_q, rt_d, imm_q, imm_d;
  logic [31:0]      instr_q, instr_d;
  logic             fwd_rs_q, fwd_rs_d, fwd_rt_q, fwd_rt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load;

  assign load = in_valid && in_ready;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    imm_d    = imm_q;
    fwd_rs_d = fwd_rs_q;
    fwd_rt_d = fwd_rt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (ex_ready || !valid_q) begin
      valid_d = load;
      if (load) begin
        pc_d     = in_pc;
        instr_d  = in_instr;
        rs_d     = rs_val;
        rt_d     = rt_val;
        imm_d    = imm_ext;
        fwd_rs_d = fwd_rs;
        fwd_rt_d = fwd_rt;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !flush && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      instr_q  <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      imm_q    <= '0;
      fwd_rs_q <= 1'b0;
      fwd_rt_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      imm_q    <= imm_d;
      fwd_rs_q <= fwd_rs_d;
      fwd_rt_q <= fwd_rt_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign out_instr   = instr_q;
  assign out_rs_data = rs_q;
  assign out_rt_data = rt_q;
  assign out_imm     = imm_q;
  assign out_fwd_rs  = fwd_rs_q;
  assign out_fwd_rt  = fwd_rt_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_stage_hz.sv
// Directed bench for id_stage_hz with a 4-bit stall counter so saturation is reachable quickly.
module tb_id_stage_hz;

  localparam int XLEN  = 32;
  localparam int NREG  = 32;
  localparam int CNT_W = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, ex_ready, flush;
  logic [31:0]     in_pc, in_instr;
  logic            ex_wr_en, ex_is_load, mem_wr_en, wb_en;
  logic [4:0]      ex_wr_addr, mem_wr_addr, wb_addr;
  logic [31:0]     mem_data, wb_data;
  logic            out_valid, out_fwd_rs, out_fwd_rt, redirect_valid;
  logic [31:0]     out_pc, out_rs_data, out_rt_data, out_imm, out_instr, redirect_pc;
  logic [CNT_W-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  id_stage_hz #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .ex_ready(ex_ready), .flush(flush),
    .ex_wr_en(ex_wr_en), .ex_wr_addr(ex_wr_addr), .ex_is_load(ex_is_load),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_data(mem_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_rs_data(out_rs_data),
    .out_rt_data(out_rt_data), .out_imm(out_imm), .out_instr(out_instr),
    .out_fwd_rs(out_fwd_rs), .out_fwd_rt(out_fwd_rt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  initial begin
    reset = 1'b0; in_valid = 0; in_pc = 0; in_instr = 0; ex_ready = 1; flush = 0;
    ex_wr_en = 0; ex_wr_addr = 0; ex_is_load = 0;
    mem_wr_en = 0; mem_wr_addr = 0; mem_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    tick();
    reset = 1'b1;

    // WB write-through: r5=0x1234 read by ID in the same cycle
    wb_en = 1; wb_addr = 5; wb_data = 32'h1234;
    in_valid = 1; in_pc = 32'h100; in_instr = rtype(5, 0, 4, 6'h20);
    #1 check("wt_in_ready", 64'(in_ready), 64'd1);
    tick();
    check("wt_out_valid", 64'(out_valid), 64'd1);
    check("wt_rs_data", 64'(out_rs_data), 64'h1234);
    check("wt_out_pc", 64'(out_pc), 64'h100);

    // Write to r0 ignored; r5 now comes from the array
    wb_addr = 0; wb_data = 32'hDEAD;
    in_pc = 32'h104; in_instr = rtype(0, 5, 4, 6'h20);
    tick();
    check("r0_rs_data", 64'(out_rs_data), 64'd0);
    check("r5_rt_data", 64'(out_rt_data), 64'h1234);
    wb_en = 0;

    // Load-use: lw r3 in EX, add r4,r3,r2 in ID
    ex_wr_en = 1; ex_wr_addr = 3; ex_is_load = 1;
    in_pc = 32'h108; in_instr = rtype(3, 2, 4, 6'h20);
    #1 check("lu_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("lu_bubble", 64'(out_valid), 64'd0);
    check("lu_stall_cnt", 64'(stall_cnt), 64'd1);
    ex_wr_en = 0; ex_is_load = 0;
    mem_wr_en = 1; mem_wr_addr = 3; mem_data = 32'hAAAA;
    #1 check("lu_ready_after", 64'(in_ready), 64'd1);
    tick();
    check("lu_issue_valid", 64'(out_valid), 64'd1);
    check("lu_issue_rs", 64'(out_rs_data), 64'hAAAA);
    check("lu_issue_fwd", 64'(out_fwd_rs), 64'd0);

    // ALU producer in EX: sub r6,r3,r1 forwards in EX without stalling
    mem_wr_en = 0;
    ex_wr_en = 1; ex_wr_addr = 3;
    in_pc = 32'h10C; in_instr = rtype(3, 1, 6, 6'h22);
    tick();
    check("fwd_valid", 64'(out_valid), 64'd1);
    check("fwd_rs", 64'(out_fwd_rs), 64'd1);
    check("fwd_rt", 64'(out_fwd_rt), 64'd0);
    check("fwd_no_stall", 64'(stall_cnt), 64'd1);

    // beq r3,r0 needs r3 in ID: stall, then resolve from MEM
    in_pc = 32'h200; in_instr = itype(6'h04, 3, 0, 16'h0002);
    #1 check("br_in_ready", 64'(in_ready), 64'd0);
    check("br_no_redirect", 64'(redirect_valid), 64'd0);
    tick();
    check("br_stall_cnt", 64'(stall_cnt), 64'd2);
    ex_wr_en = 0;
    mem_wr_en = 1; mem_wr_addr = 3; mem_data = 32'h0;
    #1 check("br_mem_redirect", 64'(redirect_valid), 64'd1);
    check("br_mem_target", 64'(redirect_pc), 64'h20C);
    tick();
    mem_wr_en = 0;

    // Backward branch to itself, then bne with equal operands
    in_pc = 32'h00400010; in_instr = itype(6'h04, 5, 5, 16'hFFFF);
    #1 check("beq_self_valid", 64'(redirect_valid), 64'd1);
    check("beq_self_target", 64'(redirect_pc), 64'h00400010);
    in_instr = itype(6'h05, 5, 5, 16'hFFFF);
    #1 check("bne_eq_valid", 64'(redirect_valid), 64'd0);
    // j keeps the upper nibble of pc+4
    in_pc = 32'h1FFFFFFC; in_instr = {6'h02, 26'h0000040};
    #1 check("j_target", 64'(redirect_pc), 64'h20000100);
    in_pc = 32'h300; in_instr = rtype(5, 0, 0, 6'h08);
    #1 check("jr_valid", 64'(redirect_valid), 64'd1);
    check("jr_target", 64'(redirect_pc), 64'h1234);

    // Immediate extension
    in_instr = itype(6'h0D, 0, 7, 16'h8000);
    tick();
    check("ori_zext", 64'(out_imm), 64'h00008000);
    in_pc = 32'h304; in_instr = itype(6'h08, 0, 7, 16'h8000);
    tick();
    check("addi_sext", 64'(out_imm), 64'hFFFF8000);

    // EX backpressure holds the slot; flush then empties it
    ex_ready = 0; in_pc = 32'h308;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("hold_out_pc", 64'(out_pc), 64'h304);
      check("hold_out_valid", 64'(out_valid), 64'd1);
    end
    flush = 1;
    tick();
    check("flush_valid", 64'(out_valid), 64'd0);
    ex_ready = 1;

    // Flush beats hazard: no count, no redirect
    ex_wr_en = 1; ex_wr_addr = 3; ex_is_load = 1;
    in_instr = rtype(3, 2, 4, 6'h20);
    tick();
    check("flush_hz_cnt", 64'(stall_cnt), 64'd2);
    check("flush_hz_valid", 64'(out_valid), 64'd0);
    in_instr = {6'h02, 26'h0000040};
    #1 check("flush_no_redirect", 64'(redirect_valid), 64'd0);
    flush = 0;

    // Counter saturation: 2^CNT_W+2 hazard cycles
    in_instr = rtype(3, 2, 4, 6'h20);
    for (int i = 0; i < (1 << CNT_W) + 2; i++) tick();
    check("sat_cnt", 64'(stall_cnt), 64'hF);

    // Async reset mid-stall, observed before any clock edge
    #2 reset = 0;
    #1 check("arst_cnt", 64'(stall_cnt), 64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_pc", 64'(out_pc), 64'd0);
    check("arst_imm", 64'(out_imm), 64'd0);
    reset = 1;
    ex_wr_en = 0; ex_is_load = 0;
    in_pc = 32'h400; in_instr = rtype(5, 0, 4, 6'h20);
    tick();
    check("post_rst_valid", 64'(out_valid), 64'd1);
    check("post_rst_rf_clear", 64'(out_rs_data), 64'd0);
    check("post_rst_pc", 64'(out_pc), 64'h400);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_stage_hz.md
Name: id_stage_hz

Overview:
Parametrised decode stage for the 5-stage MIPS pipeline, successor to the current combinational decode stage. Holds the register file, MEM/WB operand bypass, load-use and branch-dependency stall detection, and early branch/jump redirect. Also owns the registered ID/EX pipeline register with a valid/ready handshake and a stall-cycle counter. Sits between the IF/ID register and EX.

Parameters:
XLEN, 32, datapath width (≥32)
NREG, 32, register count (power of 2, r0 hardwired zero)
AW, $clog2(NREG), register address width (derived, not overridable)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  ID accepts this cycle (IF must hold when 0)
in_pc  in  XLEN  instruction PC
in_instr  in  32  instruction word
ex_ready  in  1  EX can accept the ID/EX contents
flush  in  1  kill instruction in ID and the ID/EX slot
ex_wr_en  in  1  instruction in EX writes a register
ex_wr_addr  in  AW  its destination
ex_is_load  in  1  instruction in EX is a load
mem_wr_en  in  1  MEM-stage write pending
mem_wr_addr  in  AW  MEM destination
mem_data  in  XLEN  MEM result
wb_en  in  1  register-file write
wb_addr  in  AW  write address
wb_data  in  XLEN  write data
out_valid  out  1  ID/EX slot valid
out_pc, out_rs_data, out_rt_data, out_imm  out  XLEN  registered operands and sign/zero-extended immediate
out_instr  out  32  registered instruction
out_fwd_rs, out_fwd_rt  out  1  EX must take its own previous ALU result for this operand
redirect_valid  out  1  taken branch, j/jal or jr this cycle (combinational)
redirect_pc  out  XLEN  target
stall_cnt  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (reset=0, async): all registers 0; out_valid=0, out_* = 0, stall_cnt=0; register file cleared.
- Register file: write on clk rise when wb_en && wb_addr!=0. Read is combinational with write-through: read addr == wb_addr && wb_en && addr!=0 returns wb_data.
- Operand select per source, in priority order:
  1. addr==0 → 0
  2. MEM match (mem_wr_en) → mem_data
  3. otherwise → regfile/bypass value
- uses_rs: all opcodes except j, jal, lui. uses_rt: R-type, beq, bne, store.
- Hazard, active only when in_valid and the source is nonzero and used, with ex_wr_en && ex_wr_addr==source:
  - ex_is_load → stall.
  - consumer is beq/bne/blez/bgtz/jr → stall.
  - otherwise no stall; set out_fwd_rs/out_fwd_rt.
- in_ready = !hazard && (ex_ready || !out_valid).
- Redirect is raised only when in_valid && in_ready && !flush.
  - Branch target: in_pc+4 + (sext(imm)<<2), width XLEN, wraps modulo 2^XLEN.
  - j/jal target: {(in_pc+4)[XLEN-1:28], idx26, 2'b00}.
  - jr target: forwarded rs.
  - Branch conditions: beq (rs==rt), bne (rs!=rt), blez (signed rs ≤ 0), bgtz (signed rs > 0).
- ID/EX update on clk rise:
  - flush → out_valid=0; the ID instruction is dropped.
  - Else if ex_ready || !out_valid: load in_valid&&in_ready into out_valid and, when loading, all payload fields.
  - Hazard → bubble: out_valid=0.
  - Else (EX not ready) hold all outputs.
- Immediate extension: zero-extended for andi/ori/xori, sign-extended otherwise.
- stall_cnt increments when in_valid && hazard && !flush; saturates at all-ones.
- Simultaneous flush and hazard: flush wins; stall_cnt does not count.
- Reset mid-stall clears the state immediately; first valid after release is decoded normally.

Decomposition:
- Shared package mips_pkg: opcode/funct constants (OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_J, OP_JAL, OP_LUI, OP_LW, FN_JR, ...), and XLEN default.
- One sub-module id_regfile (NREG×XLEN, async active-low clear, write-through read).
- Hazard, forward, and branch logic stay in the top.

Test Plan:
- wb writes r5=0x1234 while ID reads r5 same cycle → out_rs_data=0x1234 next edge; write to r0 ignored, reads 0.
- lw r3 in EX, ID add r4,r3,r2 → one bubble (out_valid=0), in_ready=0 one cycle, stall_cnt 0→1; then add issues.
- add r3 in EX, ID sub r6,r3,r1 → no stall, out_fwd_rs=1; same with beq r3,r0 → one stall, then redirect once r3 is in MEM via mem_data.
- beq at pc=0x00400010, imm=0xFFFF, rs==rt → redirect_valid=1, redirect_pc=0x00400010; bne with equal operands → redirect_valid=0.
- ex_ready=0 for 3 cycles with out_valid=1 → outputs held, in_ready=0; flush asserted → out_valid=0 next edge.
- Force 2^CNT_W+2 hazard cycles → stall_cnt saturates at all-ones; async reset mid-run → all outputs 0 without a clock edge.
